// File: rtl/shift_register_sipo.sv
// -----------------------------------------------------------------------------
// shift_register_sipo
//
// Purpose:
//   Serial-in / parallel-out frame assembler. Serial bits arrive on a
//   valid/ready handshake and are shifted into a WIDTH-bit register. Once
//   WIDTH bits are held, the frame is presented on pout with pout_valid=1.
//   It stays there until the downstream consumer takes it with pout_ready.
//   A frame hand-off and the first bit of the next frame can share one
//   clock edge, so a continuous bit stream never stalls while the consumer
//   is ready.
//
// Parameters:
//   WIDTH      frame length in bits (2..32)
//   MSB_FIRST  1: first received bit ends up in pout[WIDTH-1] (shift left)
//              0: first received bit ends up in pout[0]       (shift right)
//
// Ports:
//   clk         in   rising-edge clock for all state
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous discard of the frame being assembled
//   sin         in   serial data bit
//   sin_valid   in   sin carries a bit this cycle
//   sin_ready   out  block accepts a bit this cycle
//   pout        out  assembled parallel frame (straight from the register)
//   pout_valid  out  pout holds a complete frame
//   pout_ready  in   consumer takes the frame this cycle
//   bit_cnt     out  number of bits held in the current frame
// -----------------------------------------------------------------------------
module shift_register_sipo #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     sin,
  input  logic                     sin_valid,
  output logic                     sin_ready,
  output logic [WIDTH-1:0]         pout,
  output logic                     pout_valid,
  input  logic                     pout_ready,
  output logic [$clog2(WIDTH):0]   bit_cnt
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // State
  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;

  // Next-state values
  state_t             w_state_next;
  logic [WIDTH-1:0]   w_shift_next;
  logic [CNT_W-1:0]   w_cnt_next;

  // Helpers
  logic [WIDTH-1:0]   w_shifted;
  logic               w_sin_ready;
  logic               w_accept;

  // ---------------------------------------------------------------------------
  // Register contents after one accepted bit. The shift direction is fixed at
  // elaboration so only one of the two paths exists in hardware.
  // ---------------------------------------------------------------------------
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shift[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign w_shifted = {sin, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // While filling we always take a bit. Once full, a new bit can only enter
  // on the same edge that the held frame leaves, so readiness follows the
  // consumer combinationally.
  assign w_sin_ready = (r_state == ST_FILL) ? 1'b1 : pout_ready;

  // clr wins over everything: a bit offered alongside clr is dropped.
  assign w_accept = sin_valid & w_sin_ready & ~clr;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;

    if (clr) begin
      w_state_next = ST_FILL;
      w_shift_next = '0;
      w_cnt_next   = CNT_ZERO;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            w_shift_next = w_shifted;
            w_cnt_next   = r_cnt + CNT_ONE;
            // The last bit of the frame moves us to FULL on the same edge,
            // so pout_valid rises in the very next cycle.
            if (r_cnt == CNT_LAST) begin
              w_state_next = ST_FULL;
            end
          end
        end

        ST_FULL: begin
          // Without pout_ready nothing moves: register and counter hold,
          // and any offered bit is back-pressured through sin_ready=0.
          if (pout_ready) begin
            w_state_next = ST_FILL;
            if (sin_valid) begin
              // Hand-off and first bit of the next frame share this edge.
              // WIDTH >= 2, so a count of one can never complete a frame.
              w_shift_next = w_shifted;
              w_cnt_next   = CNT_ONE;
            end else begin
              // Old contents stay in the register but are no longer valid.
              w_cnt_next   = CNT_ZERO;
            end
          end
        end

        default: begin
          w_state_next = ST_FILL;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_shift <= '0;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pout comes straight from the register, no path from sin.
  // ---------------------------------------------------------------------------
  assign sin_ready  = w_sin_ready;
  assign pout       = r_shift;
  assign pout_valid = (r_state == ST_FULL);
  assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_shift_register_sipo.sv
// -----------------------------------------------------------------------------
// tb_shift_register_sipo
//
// Purpose:
//   Self-checking bench for shift_register_sipo with WIDTH=8. Two instances
//   share the same stimulus, one per shift direction. Expected frames are
//   queued when a frame's bits are driven and compared when the DUT hands
//   the frame off (pout_valid & pout_ready).
// -----------------------------------------------------------------------------
module tb_shift_register_sipo;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic sin;
  logic sin_valid;
  logic pout_ready;

  logic             m_sin_ready, l_sin_ready;
  logic [WIDTH-1:0] m_pout,      l_pout;
  logic             m_valid,     l_valid;
  logic [CW-1:0]    m_cnt,       l_cnt;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q_msb[$];
  logic [WIDTH-1:0] q_lsb[$];

  bit tput_phase   = 1'b0;
  int valid_cycles = 0;
  int stall_cycles = 0;
  int frames_seen  = 0;

  always #5 clk = ~clk;

  shift_register_sipo #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (m_sin_ready),
    .pout       (m_pout),
    .pout_valid (m_valid),
    .pout_ready (pout_ready),
    .bit_cnt    (m_cnt)
  );

  shift_register_sipo #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (l_sin_ready),
    .pout       (l_pout),
    .pout_valid (l_valid),
    .pout_ready (pout_ready),
    .bit_cnt    (l_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // One bit on the serial input for one clock edge.
  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
  endtask

  // Drive v[7] first; queue what each direction should assemble.
  task automatic send_frame(input logic [7:0] v);
    q_msb.push_back(v);
    q_lsb.push_back(rev8(v));
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle_cycle();
    sin_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare at every hand-off, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && pout_ready) begin
      if (m_valid) begin
        chk("msb_frame_expected", 32'(q_msb.size() > 0), 32'd1);
        if (q_msb.size() > 0) chk("msb_frame", m_pout, q_msb.pop_front());
        frames_seen++;
        $display("handoff msb pout=%h", m_pout);
      end
      if (l_valid) begin
        chk("lsb_frame_expected", 32'(q_lsb.size() > 0), 32'd1);
        if (q_lsb.size() > 0) chk("lsb_frame", l_pout, q_lsb.pop_front());
        $display("handoff lsb pout=%h", l_pout);
      end
    end
    if (tput_phase) begin
      if (m_valid) valid_cycles++;
      if (sin_valid && !m_sin_ready) stall_cycles++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] rnd;

    rst_n      = 1'b0;
    clr        = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    pout_ready = 1'b0;

    // Reset state, checked before any clock edge.
    #2;
    chk("rst_pout",      m_pout,      32'h0);
    chk("rst_valid",     m_valid,     32'h0);
    chk("rst_cnt",       m_cnt,       32'h0);
    chk("rst_sin_ready", m_sin_ready, 32'h1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame B2 in both directions, consumer not ready.
    pat = 8'hB2;
    q_msb.push_back(8'hB2);
    q_lsb.push_back(8'h4D);
    for (int i = 7; i >= 0; i--) begin
      send_bit(pat[i]);
      if (i == 7) chk("first_bit_cnt", m_cnt, 32'd1);
      if (i == 5) chk("fill_cnt3", m_cnt, 32'd3);
      if (i == 1) chk("fill_not_valid", m_valid, 32'd0);
    end
    chk("b2_cnt",        m_cnt,   32'd8);
    chk("b2_valid",      m_valid, 32'd1);
    chk("b2_pout_msb",   m_pout,  32'hB2);
    chk("4d_pout_lsb",   l_pout,  32'h4D);

    // Back-pressure: five cycles with a bit offered and no consumer.
    for (int c = 0; c < 5; c++) begin
      sin       = 1'b0;
      sin_valid = 1'b1;
      @(negedge clk);
      chk("bp_sin_ready", m_sin_ready, 32'd0);
      chk("bp_pout",      m_pout,      32'hB2);
      chk("bp_cnt",       m_cnt,       32'd8);
      @(posedge clk);
      #1;
    end
    chk("bp_hold_pout", m_pout, 32'hB2);

    // Hand-off together with the first bit of the next frame.
    pout_ready = 1'b1;
    send_bit(1'b1);
    chk("handoff_cnt",   m_cnt,   32'd1);
    chk("handoff_valid", m_valid, 32'd0);

    // Four more bits -> five held, then clr with a bit offered.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("pre_clr_cnt", m_cnt, 32'd5);
    clr       = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    sin_valid = 1'b0;
    chk("clr_cnt",   m_cnt,   32'd0);
    chk("clr_pout",  m_pout,  32'h0);
    chk("clr_valid", m_valid, 32'd0);

    send_frame(8'hF0);
    chk("f0_pout",  m_pout,  32'hF0);
    chk("f0_valid", m_valid, 32'd1);
    idle_cycle();
    chk("f0_drain_cnt",   m_cnt,   32'd0);
    chk("f0_drain_valid", m_valid, 32'd0);
    chk("f0_retained",    m_pout,  32'hF0);

    // Throughput: 24 back-to-back bits, consumer always ready.
    frames_seen = 0;
    tput_phase  = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rnd = 8'($urandom_range(0, 255));
      q_msb.push_back(rnd);
      q_lsb.push_back(rev8(rnd));
      for (int i = 7; i >= 0; i--) begin
        sin       = rnd[i];
        sin_valid = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    sin_valid = 1'b0;
    idle_cycle();
    idle_cycle();
    tput_phase = 1'b0;
    chk("tput_valid_cycles", 32'(valid_cycles), 32'd3);
    chk("tput_frames",       32'(frames_seen),  32'd3);
    chk("tput_stalls",       32'(stall_cycles), 32'd0);

    // Asynchronous reset while FULL.
    pout_ready = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      pat = 8'hA5;
      send_bit(pat[i]);
    end
    chk("a5_valid", m_valid, 32'd1);
    chk("a5_pout",  m_pout,  32'hA5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",     m_valid,     32'd0);
    chk("arst_pout",      m_pout,      32'h0);
    chk("arst_cnt",       m_cnt,       32'd0);
    chk("arst_sin_ready", m_sin_ready, 32'd1);
    chk("arst_lsb_pout",  l_pout,      32'h0);
    #3;
    rst_n = 1'b1;
    send_bit(1'b1);
    chk("post_rst_cnt",  m_cnt,  32'd1);
    chk("post_rst_pout", m_pout, 32'h1);

    chk("msb_queue_empty", 32'(q_msb.size()), 32'd0);
    chk("lsb_queue_empty", 32'(q_lsb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register_sipo.md
SHIFT_REGISTER_SIPO -- requirements
Module: shift_register_sipo

Interface
REQ-001 The block SHALL accept parameter WIDTH, default 8: frame length in bits, legal range 2..32.
REQ-002 The block SHALL accept parameter MSB_FIRST, default 1:
- 1: the first received bit lands in pout[WIDTH-1].
- 0: the first received bit lands in pout[0].
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous discard of the current frame.
REQ-006 The block SHALL have port sin, input, 1 bit: serial data bit, normally the q output of the upstream d_flipflop stage.
REQ-007 The block SHALL have port sin_valid, input, 1 bit: sin carries a bit this cycle.
REQ-008 The block SHALL have port sin_ready, output, 1 bit: the block accepts a bit this cycle.
REQ-009 The block SHALL have port pout, output, WIDTH bits: assembled parallel frame.
REQ-010 The block SHALL have port pout_valid, output, 1 bit: pout holds a complete frame.
REQ-011 The block SHALL have port pout_ready, input, 1 bit: the downstream consumer takes the frame this cycle.
REQ-012 The block SHALL have port bit_cnt, output, clog2(WIDTH)+1 bits: number of bits held in the current frame.

Function
REQ-013 A bit SHALL be accepted on a rising clk edge when sin_valid=1, sin_ready=1 and clr=0.
REQ-014 On acceptance, the shift register SHALL update as follows:
- MSB_FIRST=1: shift left, inserting sin at bit 0.
- MSB_FIRST=0: shift right, inserting sin at bit WIDTH-1.
REQ-015 The block SHALL use two states, FILL and FULL.
REQ-016 In FILL:
- sin_ready=1 and pout_valid=0.
- bit_cnt SHALL increment by 1 on each accepted bit.
REQ-017 In FILL, acceptance with bit_cnt=WIDTH-1 SHALL move the block to FULL with bit_cnt=WIDTH on the same edge. pout_valid SHALL read 1 starting the following cycle.
REQ-018 In FULL:
- pout_valid=1 and sin_ready=pout_ready (combinational).
- pout and bit_cnt SHALL hold stable until the frame is taken.
REQ-019 In FULL, pout_ready=1 with sin_valid=0 SHALL return the block to FILL with bit_cnt=0. The register contents are retained but no longer valid.
REQ-020 In FULL, pout_ready=1 with sin_valid=1 SHALL do all of the following on the same edge:
- Hand off the frame.
- Accept sin as the first bit of the next frame.
- Enter FILL with bit_cnt=1.
- Lose no bit.
REQ-021 In FULL, sin_valid=1 with pout_ready=0 SHALL be back-pressured: sin_ready=0, and the register and counter SHALL remain unchanged.
REQ-022 clr=1 SHALL force FILL, bit_cnt=0 and register=0 on the next edge, with priority over acceptance and hand-off. A bit presented in the same cycle SHALL be dropped.
REQ-023 pout SHALL be driven directly from the register, with zero combinational logic from sin.
REQ-024 The block SHALL produce a first valid frame exactly WIDTH accepted bits after reset or clr, with no extra latency beyond the cycle stated in REQ-017.

Reset
REQ-025 While rst_n=0, the following SHALL hold independent of clk:
- register=0, bit_cnt=0, state=FILL.
- pout=0, pout_valid=0, sin_ready=1.
REQ-026 Reset assertion mid-frame or in FULL SHALL discard all held bits.
REQ-027 After rst_n rises, the first bit SHALL be accepted on the first rising clk edge at which sin_valid=1.

Verification
REQ-028 With WIDTH=8 and MSB_FIRST=1, the bench SHALL cover: bits 1,0,1,1,0,0,1,0 on consecutive cycles -> pout=8'hB2, pout_valid=1, bit_cnt=8.
REQ-029 With WIDTH=8 and MSB_FIRST=0, the bench SHALL cover: the same bit sequence -> pout=8'h4D.
REQ-030 The bench SHALL cover back-pressure: frame 8'hB2 held with pout_ready=0 for 5 cycles while sin_valid=1 -> sin_ready=0 and pout stays 8'hB2. Then pout_ready=1 with sin=1 -> next cycle bit_cnt=1 and pout_valid=0.
REQ-031 The bench SHALL cover clr: 5 bits accepted, then clr=1 together with sin_valid=1 -> bit_cnt=0 and register=0. The next 8 bits 1,1,1,1,0,0,0,0 (MSB_FIRST=1) -> pout=8'hF0.
REQ-032 The bench SHALL cover asynchronous reset: rst_n driven low between clk edges while in FULL -> pout_valid=0, pout=0, bit_cnt=0 immediately.
REQ-033 The bench SHALL cover throughput: 24 consecutive valid bits with pout_ready tied to 1 -> three frames, each with pout_valid high for exactly 1 cycle and no bit lost.
